// File: rtl/dm_arb_pkg.sv
// Shared types and default parameters for the data-memory arbiter.
// Imported by dm_arbiter and its counter sub-module.
package dm_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned AW_DEF         = 32;
  localparam int unsigned DW_DEF         = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned BURST_MAX_DEF  = 8;

  // Bits needed to hold the values 0..max inclusive.
  function automatic int unsigned cnt_width(input int unsigned max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load.
// Priority when several controls are active: clear, then load, then inc.
module sat_counter #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (inc && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and an ext
// loader/debug port, with bounded starvation in both directions.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned BURST_MAX  = BURST_MAX_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic          ext_lock,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic [AW-1:0] dm_addr,
  output logic          dm_read,
  output logic          dm_write,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata
);

  localparam int unsigned SW = cnt_width(STARVE_MAX);
  localparam int unsigned BW = cnt_width(BURST_MAX);

  arb_state_e    state_q, state_d;
  logic          force_cpu_q, force_cpu_d;
  logic          ext_rvalid_q, ext_rvalid_d;
  logic [DW-1:0] ext_rdata_q, ext_rdata_d;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] burst_cnt;
  logic          cpu_req, cpu_gnt, ext_gnt_c;
  logic          enter_burst, burst_inc;

  assign cpu_req = cpu_rd | cpu_wr;

  // Grants are forced low while reset is held so the DM sees no strobes.
  always_comb begin
    state_d     = state_q;
    force_cpu_d = force_cpu_q;
    cpu_gnt     = 1'b0;
    ext_gnt_c   = 1'b0;
    enter_burst = 1'b0;
    burst_inc   = 1'b0;
    if (reset) begin
      case (state_q)
        ARB: begin
          force_cpu_d = 1'b0;
          if (cpu_req && (force_cpu_q || !ext_req || (starve_cnt != SW'(STARVE_MAX)))) begin
            cpu_gnt = 1'b1;
          end else if (ext_req) begin
            ext_gnt_c = 1'b1;
          end
          if (ext_gnt_c && ext_lock) begin
            if (BURST_MAX > 1) begin
              state_d     = BURST;
              enter_burst = 1'b1;
            end else begin
              force_cpu_d = 1'b1;
            end
          end
        end
        BURST: begin
          ext_gnt_c = ext_req;
          burst_inc = ext_req;
          // Reaching the burst limit forces a CPU turn even if lock drops too.
          if (ext_req && (burst_cnt == BW'(BURST_MAX - 1))) begin
            state_d     = ARB;
            force_cpu_d = 1'b1;
          end else if (!ext_req || !ext_lock) begin
            state_d = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  sat_counter #(.MAX(STARVE_MAX), .W(SW)) u_starve_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (!ext_req || ext_gnt_c),
    .load     (1'b0),
    .load_val ('0),
    .inc      (ext_req && !ext_gnt_c),
    .cnt      (starve_cnt)
  );

  sat_counter #(.MAX(BURST_MAX), .W(BW)) u_burst_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    ((state_q == ARB) && !enter_burst),
    .load     (enter_burst),
    .load_val (BW'(1)),
    .inc      (burst_inc),
    .cnt      (burst_cnt)
  );

  always_comb begin
    dm_addr  = '0;
    dm_read  = 1'b0;
    dm_write = 1'b0;
    dm_wdata = '0;
    if (cpu_gnt) begin
      dm_addr  = cpu_addr;
      dm_read  = cpu_rd;
      dm_write = cpu_wr;
      dm_wdata = cpu_wdata;
    end else if (ext_gnt_c) begin
      dm_addr  = ext_addr;
      dm_read  = !ext_we;
      dm_write = ext_we;
      dm_wdata = ext_wdata;
    end
  end

  always_comb begin
    ext_rvalid_d = 1'b0;
    ext_rdata_d  = ext_rdata_q;
    if (ext_gnt_c && !ext_we) begin
      ext_rvalid_d = 1'b1;
      ext_rdata_d  = dm_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB;
      force_cpu_q  <= 1'b0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      force_cpu_q  <= force_cpu_d;
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  assign cpu_rdata  = dm_rdata;
  assign cpu_stall  = reset && cpu_req && !cpu_gnt;
  assign ext_gnt    = ext_gnt_c;
  assign ext_rvalid = ext_rvalid_q;
  assign ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a word-addressed DM model behind it.
// Inputs change just after the rising edge; outputs are checked on the falling edge.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_req, ext_we, ext_lock;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_read, dm_write;

  logic [31:0] mem [0:63];
  int total = 0;
  int bad = 0;
  int illegal_cnt = 0;
  int k;
  logic exp_g;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_lock   (ext_lock),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .dm_addr    (dm_addr),
    .dm_read    (dm_read),
    .dm_write   (dm_write),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata)
  );

  always @(posedge clk) begin
    if (dm_write) mem[dm_addr[7:2]] <= dm_wdata;
  end
  assign dm_rdata = mem[dm_addr[7:2]];

  // Flags the illegal simultaneous CPU read/write without failing the run.
  always @(negedge clk) begin
    if (reset) begin
      assert (!(cpu_rd && cpu_wr)) else begin
        illegal_cnt++;
        $display("note: illegal cpu_rd&cpu_wr seen at %0t", $time);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_lock = 0; ext_addr = 0; ext_wdata = 0;
  endtask

  initial begin
    idle();
    reset = 0;
    cpu_rd = 1; ext_req = 1;
    #3;
    chk("rst_ext_gnt", ext_gnt, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_rvalid", ext_rvalid, 0);
    chk("rst_rdata", ext_rdata, 0);
    chk("rst_dm_read", dm_read, 0);
    @(negedge clk);
    idle();
    reset = 1;
    next();

    // CPU-only write then read back
    cpu_wr = 1; cpu_addr = 32'h1C; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    $display("cpu wr 0x1C: dm_write=%0d stall=%0d", dm_write, cpu_stall);
    chk("cpu_wr_strobe", dm_write, 1);
    chk("cpu_wr_addr", dm_addr, 32'h1C);
    chk("cpu_wr_stall", cpu_stall, 0);
    chk("cpu_wr_egnt", ext_gnt, 0);
    next();
    cpu_wr = 0; cpu_rd = 1;
    @(negedge clk);
    $display("cpu rd 0x1C: rdata=%h", cpu_rdata);
    chk("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);
    chk("cpu_rd_stall", cpu_stall, 0);
    chk("cpu_rd_egnt", ext_gnt, 0);
    next();
    cpu_rd = 0; cpu_wr = 1; cpu_addr = 32'h08; cpu_wdata = 32'h12345678;
    @(negedge clk);
    chk("cpu_wr8_strobe", dm_write, 1);
    next();

    // Ext read alone
    idle();
    ext_req = 1; ext_we = 0; ext_addr = 32'h08;
    @(negedge clk);
    $display("ext rd 0x08: gnt=%0d", ext_gnt);
    chk("ext_rd_gnt", ext_gnt, 1);
    chk("ext_rd_dmread", dm_read, 1);
    chk("ext_rd_addr", dm_addr, 32'h08);
    chk("ext_rd_rvalid0", ext_rvalid, 0);
    next();
    idle();
    @(negedge clk);
    $display("ext rd result: rvalid=%0d rdata=%h", ext_rvalid, ext_rdata);
    chk("ext_rd_rvalid1", ext_rvalid, 1);
    chk("ext_rd_rdata", ext_rdata, 32'h12345678);
    chk("ext_rd_gnt_off", ext_gnt, 0);
    next();
    @(negedge clk);
    chk("ext_rd_rvalid_off", ext_rvalid, 0);
    chk("ext_rd_rdata_hold", ext_rdata, 32'h12345678);
    next();

    // Contention: ext waits STARVE_MAX cycles, twice in a row
    cpu_rd = 1; cpu_addr = 32'h1C;
    ext_req = 1; ext_we = 0; ext_addr = 32'h08;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      $display("contention cycle %0d: ext_gnt=%0d stall=%0d rvalid=%0d", i, ext_gnt, cpu_stall, ext_rvalid);
      chk("cont_egnt", ext_gnt, (i % 5) == 4);
      chk("cont_stall", cpu_stall, (i % 5) == 4);
      chk("cont_rvalid", ext_rvalid, i == 5);
      next();
    end
    idle();
    @(negedge clk);
    chk("cont_rvalid_end", ext_rvalid, 1);
    chk("cont_rdata_end", ext_rdata, 32'h12345678);
    next();

    // Locked burst of 12 writes with the CPU reading throughout
    k = 0;
    ext_req = 1; ext_we = 1; ext_lock = 1;
    ext_addr = 32'h20; ext_wdata = 32'hA0000000;
    @(negedge clk);
    chk("burst_first_gnt", ext_gnt, 1);
    chk("burst_first_wr", dm_write, 1);
    next();
    k = 1;
    cpu_rd = 1; cpu_addr = 32'h1C;
    for (int j = 1; j < 16; j++) begin
      exp_g = (j <= 7) || (j >= 12);
      ext_addr = 32'h20 + 32'(4 * k);
      ext_wdata = 32'hA0000000 + 32'(k);
      @(negedge clk);
      $display("burst cycle %0d: ext_gnt=%0d stall=%0d dm_addr=%h", j, ext_gnt, cpu_stall, dm_addr);
      chk("burst_egnt", ext_gnt, exp_g);
      chk("burst_stall", cpu_stall, exp_g);
      if (j == 8) chk("burst_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
      next();
      if (exp_g) k++;
    end
    idle();
    @(negedge clk);
    chk("burst_drop_gnt", ext_gnt, 0);
    next();
    foreach (mem[idx]) begin
      if (idx == 0 || idx == 7 || idx == 8 || idx == 11) begin
        cpu_rd = 1; cpu_addr = 32'h20 + 32'(4 * idx);
        @(negedge clk);
        $display("readback k=%0d: rdata=%h", idx, cpu_rdata);
        chk("burst_readback", cpu_rdata, 32'hA0000000 + 32'(idx));
        chk("burst_readback_stall", cpu_stall, 0);
        next();
      end
    end
    idle();
    next();

    // Reset asserted during burst cycle 3
    ext_req = 1; ext_we = 0; ext_lock = 1; ext_addr = 32'h1C;
    @(negedge clk);
    chk("rstb_gnt1", ext_gnt, 1);
    next();
    @(negedge clk);
    chk("rstb_gnt2", ext_gnt, 1);
    next();
    cpu_rd = 1; cpu_addr = 32'h1C;
    chk("rstb_rvalid_pre", ext_rvalid, 1);
    #1;
    chk("rstb_stall_pre", cpu_stall, 1);
    reset = 0;
    #1;
    $display("mid-burst reset: rvalid=%0d gnt=%0d stall=%0d", ext_rvalid, ext_gnt, cpu_stall);
    chk("rstb_rvalid", ext_rvalid, 0);
    chk("rstb_gnt", ext_gnt, 0);
    chk("rstb_stall", cpu_stall, 0);
    chk("rstb_dmread", dm_read, 0);
    @(negedge clk);
    reset = 1;
    #1;
    $display("after release: gnt=%0d stall=%0d dm_read=%0d", ext_gnt, cpu_stall, dm_read);
    chk("rstb_post_egnt", ext_gnt, 0);
    chk("rstb_post_stall", cpu_stall, 0);
    chk("rstb_post_dmread", dm_read, 1);
    next();
    idle();
    next();

    // Illegal simultaneous CPU read and write
    cpu_rd = 1; cpu_wr = 1; cpu_addr = 32'h3C; cpu_wdata = 32'h55;
    @(negedge clk);
    $display("illegal rd&wr: dm_read=%0d dm_write=%0d", dm_read, dm_write);
    chk("illegal_dmread", dm_read, 1);
    chk("illegal_dmwrite", dm_write, 1);
    next();
    idle();
    chk("illegal_flagged", illegal_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
